// File: rtl/axi_read_master_pkg.sv
// axi_read_master_pkg: shared AXI widths, burst/resp encodings and burst limits
package axi_read_master_pkg;
  localparam int AXI_DATA_WIDTH = 32;
  localparam int AXI_ID_WIDTH = 4;
  localparam int BOUNDARY_4K = 4096;
  localparam int MAX_BURST = 16;
  typedef enum logic [1:0] {BURST_FIXED = 2'b00, BURST_INCR = 2'b01, BURST_WRAP = 2'b10} burst_t;
  typedef enum logic [1:0] {RESP_OKAY, RESP_EXOKAY, RESP_SLVERR, RESP_DECERR} resp_t;
endpackage

// File: rtl/axi_burst_calc.sv
// axi_burst_calc: beats of the next burst = min(remaining, 16, beats to 4 KB boundary)
module axi_burst_calc
  import axi_read_master_pkg::*;
#(
  parameter int SIZE = 2
) (
  input  logic [11:0] addr,
  input  logic [15:0] remaining,
  output logic [4:0]  beats
);
  logic [12:0] to_bound;
  logic [15:0] cap;
  always_comb begin
    to_bound = (13'(BOUNDARY_4K) - {1'b0, addr}) >> SIZE;
    cap = to_bound < 13'(MAX_BURST) ? 16'(to_bound) : 16'(MAX_BURST);
    beats = 5'(remaining < cap ? remaining : cap);
  end
endmodule

// File: rtl/axi_read_master.sv
// axi_read_master: fetches a block as 4 KB-safe INCR bursts (one outstanding) and streams it out valid/ready
module axi_read_master
  import axi_read_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = AXI_DATA_WIDTH,
  parameter int ID_WIDTH = AXI_ID_WIDTH,
  parameter int ARID = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [15:0]           len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  data_valid_o,
  input  logic                  data_ready_i,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [ID_WIDTH-1:0]   arid,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [ID_WIDTH-1:0]   rid,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast
);
  localparam int SIZE = $clog2(DATA_WIDTH / 8);
  localparam logic [ID_WIDTH-1:0] ID = ID_WIDTH'(ARID);
  typedef enum logic [1:0] {IDLE, AR, R} state_t;
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] addr, addr_a;
  logic [15:0] rem;
  logic [3:0] len;
  logic [4:0] cnt, beats, calc_beats;
  logic start, last, bad, err, done;
  axi_burst_calc #(.SIZE(SIZE)) u_calc (
    .addr     (state == IDLE ? addr_a[11:0] : addr[11:0]),
    .remaining(state == IDLE ? len_i : rem),
    .beats    (calc_beats)
  );
  always_comb begin
    start = state == IDLE && start_i;
    addr_a = addr_i & ~ADDR_WIDTH'(DATA_WIDTH / 8 - 1);
    beats = {1'b0, len} + 5'd1;
    rready = state == R && data_ready_i;
    last = rvalid && rready && cnt == 5'd1;
    bad = rresp != RESP_OKAY || rid != ID || rlast != (cnt == 5'd1);
    state_n = state == IDLE ? (start && len_i != 16'd0 ? AR : IDLE)
            : state == AR ? (arready ? R : AR)
            : last ? (rem != 16'd0 ? AR : IDLE) : R;
  end
  assign arvalid = state == AR;
  assign araddr = addr;
  assign arlen = {4'd0, len};
  assign arsize = arvalid ? 3'(SIZE) : 3'd0;
  assign arburst = arvalid ? BURST_INCR : 2'b00;
  assign arid = arvalid ? ID : '0;
  assign data_o = rdata;
  assign data_valid_o = state == R && rvalid;
  assign busy_o = state != IDLE;
  assign done_o = done;
  assign error_o = err;
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr <= '0;
      rem <= '0;
      len <= '0;
      cnt <= '0;
      err <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= (start && len_i == 16'd0) || (last && rem == 16'd0);
      if (start) begin
        addr <= addr_a;
        rem <= len_i;
        err <= 1'b0;
      end
      if (state_n == AR && state != AR) len <= 4'(calc_beats - 5'd1);
      if (arvalid && arready) begin
        addr <= addr + (ADDR_WIDTH'(beats) << SIZE);
        rem <= rem - 16'(beats);
        cnt <= beats;
      end
      if (rvalid && rready) begin
        cnt <= cnt - 5'd1;
        if (bad) err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_axi_read_master.sv
// tb_axi_read_master: randomized scoreboard bench with a reactive AXI read slave
module tb_axi_read_master;
  logic clk = 1'b0;
  logic rst_n, start_i, data_ready_i, arready, rvalid, rlast;
  logic [31:0] addr_i, data_o, araddr, rdata;
  logic [15:0] len_i;
  logic busy_o, done_o, error_o, data_valid_o, arvalid, rready;
  logic [3:0] arid, rid;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst, rresp;

  always #5 clk = ~clk;

  axi_read_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .ARID(0)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .addr_i(addr_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .data_o(data_o),
    .data_valid_o(data_valid_o), .data_ready_i(data_ready_i),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .rvalid(rvalid), .rready(rready), .rid(rid),
    .rdata(rdata), .rresp(rresp), .rlast(rlast)
  );

  typedef struct {logic [31:0] a; logic [7:0] l;} ar_t;
  typedef struct {logic [31:0] d; logic l; logic [1:0] resp; logic [3:0] id;} beat_t;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int sbeat = 0;
  int err_kind = 0;
  int err_at = -1;
  int chk_next = 0;
  bit chk_err = 0;
  bit bp = 0;
  logic [31:0] exp_q[$];
  ar_t exp_ar[$];
  beat_t sq[$];

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // slave: zero-latency arready, random rvalid gaps, optional fault injection
  initial begin
    bit arf, rf;
    logic [31:0] a;
    logic [7:0] l;
    beat_t b;
    arready = 1'b1;
    rvalid = 1'b0;
    rdata = '0;
    rlast = 1'b0;
    rresp = 2'b00;
    rid = '0;
    data_ready_i = 1'b1;
    forever begin
      @(negedge clk);
      arf = arvalid && arready;
      rf = rvalid && rready;
      a = araddr;
      l = arlen;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        sq.delete();
        rvalid = 1'b0;
      end else begin
        if (arf)
          for (int i = 0; i <= int'(l); i++) begin
            b.d = mem(a + 32'(4 * i));
            b.l = (i == int'(l));
            b.resp = 2'b00;
            b.id = 4'd0;
            if (err_kind != 0 && sbeat == err_at) begin
              if (err_kind == 1) b.resp = 2'b10;
              if (err_kind == 2) b.id = 4'd5;
              if (err_kind == 3) b.l = ~b.l;
            end
            sbeat++;
            sq.push_back(b);
          end
        if (rf) void'(sq.pop_front());
        if (!(rvalid && !rf)) rvalid = sq.size() > 0 && $urandom_range(3) != 0;
        if (sq.size() > 0) begin
          rdata = sq[0].d;
          rlast = sq[0].l;
          rresp = sq[0].resp;
          rid = sq[0].id;
        end else rdata = $urandom;
      end
      data_ready_i = bp ? 1'($urandom_range(1)) : 1'b1;
    end
  end

  // monitor: pops expected ARs and beats, checks timing of burst ends and errors
  initial begin
    ar_t e;
    logic [31:0] d;
    int bl;
    bl = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (chk_err) chk("err_rise", 32'(error_o), 32'd1);
        chk_err = 0;
        if (chk_next == 1) chk("ar_after_burst", 32'(arvalid), 32'd1);
        if (chk_next == 2) begin
          chk("done_pulse", 32'(done_o), 32'd1);
          chk("done_not_busy", 32'(busy_o), 32'd0);
        end
        chk_next = 0;
        if (rready || data_valid_o) chk("rready_mirror", 32'(rready), 32'(data_ready_i));
        if (arvalid && arready) begin
          if (exp_ar.size() == 0) chk("extra_ar", 32'd1, 32'd0);
          else begin
            e = exp_ar.pop_front();
            chk("araddr", araddr, e.a);
            chk("arlen", 32'(arlen), 32'(e.l));
            chk("arsize", 32'(arsize), 32'd2);
            chk("arburst", 32'(arburst), 32'd1);
            chk("arid", 32'(arid), 32'd0);
            bl = int'(e.l) + 1;
          end
        end
        if (data_valid_o && data_ready_i) begin
          if (exp_q.size() == 0) chk("extra_beat", 32'd1, 32'd0);
          else begin
            d = exp_q.pop_front();
            chk("data", data_o, d);
          end
          if (rresp != 2'b00 || rid != 4'd0 || rlast != (bl == 1)) chk_err = 1;
          bl--;
          if (bl == 0) chk_next = exp_ar.size() > 0 ? 1 : 2;
        end
        if (done_o) done_cnt++;
      end
    end
  end

  task automatic model(input logic [31:0] a, input int n);
    logic [31:0] ca;
    int rem, b, bound;
    ca = a & ~32'h3;
    rem = n;
    for (int i = 0; i < n; i++) exp_q.push_back(mem(ca + 32'(4 * i)));
    while (rem > 0) begin
      bound = (4096 - int'(ca % 4096)) / 4;
      b = rem < 16 ? rem : 16;
      if (bound < b) b = bound;
      exp_ar.push_back('{ca, 8'(b - 1)});
      ca += 32'(4 * b);
      rem -= b;
    end
  endtask

  task automatic run(input logic [31:0] a, input int n, input int kind, input bit poke);
    int d0, t;
    model(a, n);
    err_kind = kind;
    err_at = sbeat + 2;
    d0 = done_cnt;
    @(posedge clk);
    #1;
    start_i = 1'b1;
    addr_i = a;
    len_i = 16'(n);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    addr_i = $urandom;
    len_i = 16'($urandom);
    @(negedge clk);
    chk("start_busy", 32'(busy_o), 32'(n != 0));
    chk("start_arvalid", 32'(arvalid), 32'(n != 0));
    chk("start_done", 32'(done_o), 32'(n == 0));
    chk("start_err_clear", 32'(error_o), 32'd0);
    if (poke) begin
      repeat (5) @(posedge clk);
      #1;
      start_i = 1'b1;
      len_i = 16'd3;
      @(posedge clk);
      #1;
      start_i = 1'b0;
    end
    for (t = 0; t < 3000 && done_cnt == d0; t++) @(negedge clk);
    if (t >= 3000) chk("done_timeout", 32'd1, 32'd0);
    repeat (3) @(negedge clk);
    chk("done_once", 32'(done_cnt - d0), 32'd1);
    chk("beats_left", 32'(exp_q.size()), 32'd0);
    chk("ars_left", 32'(exp_ar.size()), 32'd0);
    chk("error_final", 32'(error_o), 32'(kind != 0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start_i = 1'b0;
    addr_i = '0;
    len_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_rready", 32'(rready), 32'd0);
    chk("rst_dvalid", 32'(data_valid_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_error", 32'(error_o), 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_arlen", 32'(arlen), 32'd0);
    chk("rst_arsize", 32'(arsize), 32'd0);
    chk("rst_arburst", 32'(arburst), 32'd0);
    chk("rst_arid", 32'(arid), 32'd0);
    rst_n = 1'b1;
    run(32'h0000, 8, 0, 0);
    run(32'h0100, 40, 0, 0);
    run(32'h0FF0, 8, 0, 0);
    bp = 1;
    run(32'h2000, 40, 0, 0);
    for (int i = 0; i < 5; i++) run($urandom & 32'hFFFF, $urandom_range(1, 50), 0, 0);
    bp = 0;
    run(32'h0040, 0, 0, 0);
    run(32'h0500, 40, 0, 1);
    run(32'h0600, 8, 1, 0);
    run(32'h0700, 8, 0, 0);
    run(32'h0800, 8, 2, 0);
    run(32'h0900, 8, 3, 0);
    run(32'h0A03, 4, 0, 0);
    model(32'h0C00, 40);
    @(posedge clk);
    #1;
    start_i = 1'b1;
    addr_i = 32'h0C00;
    len_i = 16'd40;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    exp_q.delete();
    exp_ar.delete();
    chk_next = 0;
    chk_err = 0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_arvalid", 32'(arvalid), 32'd0);
    chk("midrst_rready", 32'(rready), 32'd0);
    rst_n = 1'b1;
    run(32'h1FC0, 24, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi_read_master.md
# axi_read_master

AXI read-channel initiator that fetches a contiguous block of memory and delivers it as a valid/ready data stream. It drives `AXI_AR_CH` and consumes `AXI_R_CH`, so it is the counterpart of the AXI slave memory model on the read path. It splits each request into INCR bursts of at most 16 beats and never lets a burst cross a 4 KB boundary. Only one burst is outstanding at a time.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: AXI address width.
- `DATA_WIDTH`, `` `AXI_DATA_WIDTH ``: beat width. Must be a power of two, at least 32.
- `ID_WIDTH`, `` `AXI_ID_WIDTH ``: AXI ID width.
- `ARID`, 0: constant ID driven on `arid` and expected on `rid`.

Ports:
- `clk` input 1: the single clock.
- `rst_n` input 1: reset, synchronous and active-low.
- `start_i` input 1: request strobe. Sampled only in IDLE.
- `addr_i` input ADDR_WIDTH: start byte address. Low log2(DATA_WIDTH/8) bits are forced to 0.
- `len_i` input 16: transfer length in beats. 0 is legal.
- `busy_o` output 1: high while a transfer is in progress.
- `done_o` output 1: one-cycle completion pulse.
- `error_o` output 1: sticky error flag. Cleared by an accepted start.
- `data_o` output DATA_WIDTH: stream data.
- `data_valid_o` output 1: stream valid.
- `data_ready_i` input 1: stream ready.
- `ar_ch` AXI_AR_CH (master side): drives `arvalid`, `arid`, `araddr`, `arlen`, `arsize`, `arburst`; receives `arready`.
- `r_ch` AXI_R_CH (master side): receives `rvalid`, `rid`, `rdata`, `rresp`, `rlast`; drives `rready`.

## Operation
- States:
  - **IDLE**: on `start_i`, latch the address, set the remaining-beat count to `len_i` and clear `error_o`. Go to AR if `len_i != 0`. Otherwise stay in IDLE and pulse `done_o`.
  - **AR**: assert `arvalid` and hold it until `arready`.
  - **R**: stream beats.
- Burst length:
  - Beats to the 4 KB boundary = (4096 − addr[11:0]) / (DATA_WIDTH/8).
  - Burst beats = min(remaining, 16, beats to boundary).
  - `arlen` = burst beats − 1.
  - `arsize` = log2(DATA_WIDTH/8).
  - `arburst` = 2'b01 (INCR).
  - `arid` = ARID.
- The burst length is computed in the cycle the FSM enters AR and is registered. `araddr`, `arlen` and `arsize` stay stable while `arvalid` is high.
- AR handshake (`arvalid & arready`): the address advances by burst beats × DATA_WIDTH/8, remaining decreases by burst beats, and the FSM goes to R with the beat counter loaded with burst beats.
- R phase:
  - `rready` = `data_ready_i`.
  - `data_valid_o` = `rvalid`.
  - `data_o` = `rdata`.
  - The path is combinational pass-through with no buffering. A beat transfers when `rvalid & rready`.
- Burst end:
  - The burst ends on the internally counted last beat.
  - If `rlast` disagrees with the count (early or missing), set `error_o` and still use the count.
  - Any beat with `rresp != 2'b00` sets `error_o`.
  - Any beat with `rid != ARID` sets `error_o`.
  - Data is forwarded regardless of errors.
- After the last beat of a burst: go to AR if remaining > 0. Otherwise go to IDLE and pulse `done_o`.
- `start_i` outside IDLE is ignored.
- `rvalid` outside R is not accepted (`rready` = 0).

## Timing
- Reset values:
  - State IDLE.
  - `arvalid`, `rready`, `data_valid_o`, `busy_o`, `done_o`, `error_o` = 0.
  - `araddr`, `arlen`, `arsize`, `arburst`, `arid` = 0.
  - `data_o` follows `rdata`.
- Reset mid-transfer abandons the outstanding burst immediately. The bench must reset the slave in the same cycle.
- Start: `start_i` high in cycle N (IDLE) gives `arvalid` high and `busy_o` high in cycle N+1.
- First `rready`: `rready` can first be high in the cycle after the AR handshake.
- Between bursts: the final R handshake of a non-last burst in cycle M gives `arvalid` in cycle M+1.
- Completion: the final R handshake in cycle M gives `done_o` = 1 and `busy_o` = 0 in cycle M+1.
- Zero length: `start_i` with `len_i == 0` gives `done_o` in cycle N+1, `busy_o` never high, and no AR.
- `error_o` holds from the cycle after the offending beat until the next accepted start.

## Structure
- Shared constants go in the common AXI typedef header alongside `` `AXI_DATA_WIDTH `` and `` `AXI_ID_WIDTH ``:
  - burst encodings (FIXED/INCR/WRAP)
  - resp encodings (OKAY/EXOKAY/SLVERR/DECERR)
  - 4 KB boundary size
  - max AXI3 burst beats (16)
- The FSM state enum stays local to the module.
- One sub-module is natural: `axi_burst_calc`. It is a pure function from (address, remaining) to burst beats and is reused by a future write master.

## Test plan
All scenarios use DATA_WIDTH=32 and a slave model with zero-latency `arready`.
- Single burst: `addr_i`=0x0000, `len_i`=8 -> one AR with `arlen`=7, `arsize`=2, `arburst`=1. Eight beats delivered in order, then `done_o` once.
- Burst splitting: `addr_i`=0x0100, `len_i`=40 -> ARs at 0x0100/0x0140/0x0180 with `arlen` 15/15/7. 40 beats delivered, and the first AR of each subsequent burst comes one cycle after the previous `rlast` beat.
- 4 KB crossing: `addr_i`=0x0FF0, `len_i`=8 -> AR 0x0FF0 with `arlen`=3, then AR 0x1000 with `arlen`=3.
- Backpressure: `data_ready_i` toggled pseudo-randomly over a 40-beat transfer -> `rready` mirrors it. No beat is lost or duplicated, and the output matches memory.
- Edge requests: `len_i`=0 -> `done_o` in cycle N+1 and no `arvalid`. `start_i` pulsed while busy -> ignored, and the transfer count is unchanged.
- Error reporting: slave returns `rresp`=2'b10 on beat 3 of 8 -> `error_o` rises the next cycle. All 8 beats are still forwarded, `done_o` pulses, and the next start clears `error_o`.
